mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_pkg.sv | 26 ++
 rtl/mode_debouncer.sv | 59 +++++
 rtl/mode_sequencer.sv | 122 ++++++++++++
 tb/tb_mode_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared state encoding, mode indices and width helpers for the mode sequencer
package mode_pkg;

    typedef enum logic [1:0] {
        ST_STABLE   = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_MUTE     = 2'd2
    } seq_state_t;

    typedef enum int {
        FREE      = 0,
        AUTO_PLAY = 1,
        LEARNING  = 2
    } mode_idx_t;

    function automatic int calc_mode_w(input int num_modes);
        return (num_modes <= 2) ? 1 : $clog2(num_modes);
    endfunction

    function automatic int calc_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mode_debouncer.sv
// rtl/mode_debouncer.sv - synchronises mode_select, tracks a candidate mode and strobes once it has been seen long enough
module mode_debouncer #(
    parameter int NUM_MODES       = 3,
    parameter int MODE_W          = 2,
    parameter int CNT_W           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode_select,
    input  logic [MODE_W-1:0] current_mode,
    input  logic              hold,
    output logic [MODE_W-1:0] candidate,
    output logic              pending,
    output logic              stable
);

    logic [2:0]        sync_q1;
    logic [2:0]        sync_q2;
    logic [MODE_W-1:0] mapped;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= mode_select;
            sync_q2 <= sync_q1;
        end
    end

    // Out-of-range switch positions fall back to mode 0.
    always_comb begin
        mapped = '0;
        if ({1'b0, sync_q2} < 4'(NUM_MODES))
            mapped = sync_q2[MODE_W-1:0];
    end

    // While held (mute gap) the candidate is frozen so switch movement is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= '0;
            cnt       <= '0;
        end else if (hold) begin
            cnt <= '0;
        end else if (mapped != candidate) begin
            candidate <= mapped;
            cnt       <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Candidate was loaded on the first sample, so the strobe lands on the last of DEBOUNCE_CYCLES matches.
    assign pending = (mapped != current_mode);
    assign stable  = !hold && (mapped == candidate) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 2));

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - selects the active play mode with debounce and a mute gap, and muxes its speaker/LED outputs
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int NUM_MODES       = 3,
    parameter int LED_W           = 7,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int MUTE_CYCLES     = 50000,
    localparam int MODE_W         = calc_mode_w(NUM_MODES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 mode_select,
    input  logic [NUM_MODES-1:0]       speaker_in,
    input  logic [NUM_MODES*LED_W-1:0] led_in,
    output logic                       speaker,
    output logic [LED_W-1:0]           led,
    output logic                       loud,
    output logic [NUM_MODES-1:0]       mode_en,
    output logic [MODE_W-1:0]          current_mode,
    output logic                       mode_changed
);

    localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES, MUTE_CYCLES);

    seq_state_t         state, state_n;
    logic [CNT_W-1:0]   mute_cnt, mute_cnt_n;
    logic [MODE_W-1:0]  current_mode_n;
    logic [NUM_MODES-1:0] mode_en_n;
    logic               speaker_n;
    logic [LED_W-1:0]   led_n;
    logic               loud_n;
    logic               mode_changed_n;
    logic [MODE_W-1:0]  candidate;
    logic               pending;
    logic               stable;

    mode_debouncer #(
        .NUM_MODES       (NUM_MODES),
        .MODE_W          (MODE_W),
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .mode_select  (mode_select),
        .current_mode (current_mode),
        .hold         (state == ST_MUTE),
        .candidate    (candidate),
        .pending      (pending),
        .stable       (stable)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_STABLE;
            mute_cnt     <= '0;
            current_mode <= MODE_W'(FREE);
            mode_en      <= NUM_MODES'(1);
            speaker      <= 1'b0;
            led          <= '0;
            loud         <= 1'b1;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_n;
            mute_cnt     <= mute_cnt_n;
            current_mode <= current_mode_n;
            mode_en      <= mode_en_n;
            speaker      <= speaker_n;
            led          <= led_n;
            loud         <= loud_n;
            mode_changed <= mode_changed_n;
        end
    end

    always_comb begin
        state_n        = state;
        mute_cnt_n     = mute_cnt;
        current_mode_n = current_mode;
        mode_en_n      = mode_en;
        speaker_n      = speaker_in[current_mode];
        led_n          = led_in[int'(current_mode)*LED_W +: LED_W];
        loud_n         = loud;
        mode_changed_n = 1'b0;
        case (state)
            ST_STABLE: begin
                if (pending)
                    state_n = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!pending) begin
                    state_n = ST_STABLE;
                end else if (stable) begin
                    state_n    = ST_MUTE;
                    mute_cnt_n = '0;
                    mode_en_n  = '0;
                    speaker_n  = 1'b0;
                    loud_n     = 1'b0;
                end
            end
            ST_MUTE: begin
                speaker_n = 1'b0;
                led_n     = led;
                if (mute_cnt == CNT_W'(MUTE_CYCLES - 1)) begin
                    // The new mode's outputs load on the exit edge so silence lasts exactly MUTE_CYCLES.
                    state_n        = ST_STABLE;
                    mute_cnt_n     = '0;
                    current_mode_n = candidate;
                    mode_en_n      = NUM_MODES'(1) << candidate;
                    speaker_n      = speaker_in[candidate];
                    led_n          = led_in[int'(candidate)*LED_W +: LED_W];
                    loud_n         = 1'b1;
                    mode_changed_n = 1'b1;
                end else if (mute_cnt != '1) begin
                    mute_cnt_n = mute_cnt + 1'b1;
                end
            end
            default: state_n = ST_STABLE;
        endcase
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed self-checking bench for mode_sequencer
module tb_mode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode_select;
    logic [2:0]  speaker_in;
    logic [20:0] led_in;
    logic        speaker;
    logic [6:0]  led;
    logic        loud;
    logic [2:0]  mode_en;
    logic [1:0]  current_mode;
    logic        mode_changed;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc, mute_cycles, first_mute, spk_bad, loud_bad, pulses, first_pulse_mode;

    mode_sequencer #(
        .NUM_MODES       (3),
        .LED_W           (7),
        .DEBOUNCE_CYCLES (4),
        .MUTE_CYCLES     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_select  (mode_select),
        .speaker_in   (speaker_in),
        .led_in       (led_in),
        .speaker      (speaker),
        .led          (led),
        .loud         (loud),
        .mode_en      (mode_en),
        .current_mode (current_mode),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_obs();
        cyc = 0; mute_cycles = 0; first_mute = 0; spk_bad = 0;
        loud_bad = 0; pulses = 0; first_pulse_mode = -1;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (mode_en == 3'b000) begin
                mute_cycles++;
                if (first_mute == 0) first_mute = cyc;
                if (speaker !== 1'b0) spk_bad++;
                if (loud !== 1'b0) loud_bad++;
            end
            if (mode_changed === 1'b1) begin
                pulses++;
                if (pulses == 1) first_pulse_mode = int'(current_mode);
            end
        end
    endtask

    initial begin
        logic prev, nxt;
        reset       = 1'b1;
        mode_select = 3'd0;
        speaker_in  = 3'b000;
        led_in      = {7'h33, 7'h22, 7'h11};

        @(negedge clk);
        check("rst_mode_en", 32'(mode_en), 32'h1);
        check("rst_loud", 32'(loud), 32'h1);
        check("rst_speaker", 32'(speaker), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_current_mode", 32'(current_mode), 32'h0);
        check("rst_mode_changed", 32'(mode_changed), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Mode 0: speaker follows bit 0 one cycle late, bit 1 is the opposite phase.
        prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) check("spk_follow", 32'(speaker), 32'(prev));
            nxt = (i % 2 == 0);
            speaker_in = {1'b0, ~nxt, nxt};
            prev = nxt;
        end
        check("led_mode0", 32'(led), 32'h11);
        check("loud_mode0", 32'(loud), 32'h1);

        // Short glitch to mode 2 aborts the debounce.
        speaker_in = 3'b111;
        clear_obs();
        mode_select = 3'd2;
        observe(2);
        mode_select = 3'd0;
        observe(20);
        check("glitch_mute", 32'(mute_cycles), 32'd0);
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_mode_en", 32'(mode_en), 32'h1);

        // Clean change 0 -> 1.
        clear_obs();
        mode_select = 3'd1;
        observe(20);
        check("m1_first_mute", 32'(first_mute), 32'd6);
        check("m1_mute_len", 32'(mute_cycles), 32'd3);
        check("m1_spk_quiet", 32'(spk_bad), 32'd0);
        check("m1_loud_off", 32'(loud_bad), 32'd0);
        check("m1_pulses", 32'(pulses), 32'd1);
        check("m1_current_mode", 32'(current_mode), 32'd1);
        check("m1_mode_en", 32'(mode_en), 32'h2);
        check("m1_speaker", 32'(speaker), 32'h1);
        check("m1_led", 32'(led), 32'h22);

        // Invalid selector maps to mode 0.
        clear_obs();
        mode_select = 3'd3;
        observe(20);
        check("inv_mute_len", 32'(mute_cycles), 32'd3);
        check("inv_pulses", 32'(pulses), 32'd1);
        check("inv_current_mode", 32'(current_mode), 32'd0);
        check("inv_mode_en", 32'(mode_en), 32'h1);

        // Change 0 -> 1, then 1 -> 2 during the mute gap.
        clear_obs();
        mode_select = 3'd1;
        observe(7);
        mode_select = 3'd2;
        observe(30);
        check("dbl_first_mode", 32'(first_pulse_mode), 32'd1);
        check("dbl_pulses", 32'(pulses), 32'd2);
        check("dbl_mute_len", 32'(mute_cycles), 32'd6);
        check("dbl_current_mode", 32'(current_mode), 32'd2);
        check("dbl_mode_en", 32'(mode_en), 32'h4);
        check("dbl_led", 32'(led), 32'h33);

        // Reset in the middle of a mute gap acts without a clock edge.
        clear_obs();
        mode_select = 3'd0;
        observe(7);
        check("pre_rst_muted", 32'(mode_en), 32'h0);
        #2 reset = 1'b1;
        #1;
        check("arst_mode_en", 32'(mode_en), 32'h1);
        check("arst_loud", 32'(loud), 32'h1);
        check("arst_speaker", 32'(speaker), 32'h0);
        check("arst_led", 32'(led), 32'h0);
        check("arst_current_mode", 32'(current_mode), 32'h0);
        check("arst_mode_changed", 32'(mode_changed), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clear_obs();
        observe(15);
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_mute", 32'(mute_cycles), 32'd0);
        check("post_rst_mode", 32'(current_mode), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
